// File: rtl/test_packer_if.sv
// test_packer_if: sample-in / packed-word-out bundle for test_packer.
// The drop_cnt_o signal exists only when TEST_PACKER_DROP_CNT_EN is defined.
// master = upstream source plus downstream sink (drives data/valid/flush/ready),
// slave  = the packer itself.
interface test_packer_if #(
  parameter int DATA_W = 5,
  parameter int PACK_N = 4,
  parameter int CNT_W  = 8
);
  localparam int CW = $clog2(PACK_N) + 1;

  logic [DATA_W-1:0]        data_i;
  logic                     valid_i;
  logic                     flush_i;
  logic [DATA_W*PACK_N-1:0] pack_o;
  logic [CW-1:0]            cnt_o;
  logic                     valid_o;
  logic                     ready_i;
`ifdef TEST_PACKER_DROP_CNT_EN
  logic [CNT_W-1:0]         drop_cnt_o;
`endif

  modport master (
    output data_i, valid_i, flush_i, ready_i,
    input  pack_o, cnt_o, valid_o
`ifdef TEST_PACKER_DROP_CNT_EN
    , input drop_cnt_o
`endif
  );

  modport slave (
    input  data_i, valid_i, flush_i, ready_i,
    output pack_o, cnt_o, valid_o
`ifdef TEST_PACKER_DROP_CNT_EN
    , output drop_cnt_o
`endif
  );
endinterface

// File: rtl/test_packer.sv
// test_packer: gathers PACK_N consecutive DATA_W-bit samples into one word
// and offers it downstream over valid/ready. The upstream cannot be stalled,
// so there is one assembly register (acc) and one output register; samples
// that find both full are dropped.
// Optional feature: define TEST_PACKER_DROP_CNT_EN to add the saturating
// drop counter drop_cnt_o.
module test_packer #(
  parameter int DATA_W = 5,
  parameter int PACK_N = 4,
  parameter int CNT_W  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  test_packer_if.slave bus
);
  localparam int              CW        = $clog2(PACK_N) + 1;
  localparam int              WORD_W    = DATA_W * PACK_N;
  localparam logic [CW-1:0]   FILL_FULL = CW'(PACK_N);

  logic [WORD_W-1:0] r_acc;
  logic [CW-1:0]     r_fill;
  logic              r_pend;
  logic [WORD_W-1:0] r_pack;
  logic [CW-1:0]     r_cnt;
  logic              r_valid;

  logic w_slotFree;
  logic w_closed;
  logic w_xfer;
  logic w_append;
  logic w_drop;

  // A word leaves acc when it is full, or partially filled with a flush
  // pending, and the output register is empty or being emptied this edge.
  assign w_slotFree = !r_valid || bus.ready_i;
  assign w_closed   = (r_fill == FILL_FULL) || (r_pend && (r_fill != '0));
  assign w_xfer     = w_closed && w_slotFree;
  assign w_append   = bus.valid_i && !w_xfer && (r_fill != FILL_FULL);
  assign w_drop     = bus.valid_i && !w_xfer && (r_fill == FILL_FULL);

  // Assembly register: start a new word on transfer, otherwise append the
  // sample at the current fill slot and latch a flush request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_fill <= '0;
      r_pend <= 1'b0;
    end else if (w_xfer) begin
      if (bus.valid_i) begin
        r_acc  <= {{(WORD_W-DATA_W){1'b0}}, bus.data_i};
        r_fill <= CW'(1);
      end else begin
        r_acc  <= '0;
        r_fill <= '0;
      end
      r_pend <= 1'b0;
    end else begin
      if (w_append) begin
        for (int k = 0; k < PACK_N; k++) begin
          if (r_fill == CW'(k)) begin
            r_acc[k*DATA_W +: DATA_W] <= bus.data_i;
          end
        end
        r_fill <= r_fill + CW'(1);
      end
      if (bus.flush_i && ((r_fill != '0) || bus.valid_i)) begin
        r_pend <= 1'b1;
      end
    end
  end

  // Output register: load on transfer, otherwise release once accepted;
  // the word and count simply hold while the downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pack  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (w_xfer) begin
      r_pack  <= r_acc;
      r_cnt   <= r_fill;
      r_valid <= 1'b1;
    end else if (bus.ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.pack_o  = r_pack;
  assign bus.cnt_o   = r_cnt;
  assign bus.valid_o = r_valid;

`ifdef TEST_PACKER_DROP_CNT_EN
  logic [CNT_W-1:0] r_dropCnt;

  // Count dropped samples, sticking at the all-ones value until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dropCnt <= '0;
    end else if (w_drop && (r_dropCnt != '1)) begin
      r_dropCnt <= r_dropCnt + CNT_W'(1);
    end
  end

  assign bus.drop_cnt_o = r_dropCnt;
`else
  logic w_dropUnused;
  assign w_dropUnused = w_drop;
`endif

endmodule

// File: tb/tb_test_packer.sv
// tb_test_packer: directed-vector bench for test_packer (DATA_W=5, PACK_N=4).
// Drop-counter checks are compiled only with TEST_PACKER_DROP_CNT_EN.
module tb_test_packer;
  localparam int DATA_W = 5;
  localparam int PACK_N = 4;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;
  int   wordsSeen;

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  test_packer_if #(.DATA_W(DATA_W), .PACK_N(PACK_N), .CNT_W(CNT_W)) bus ();

  test_packer #(.DATA_W(DATA_W), .PACK_N(PACK_N), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Expected word: first sample in the LSBs.
  function automatic logic [19:0] packWord(input logic [4:0] a, input logic [4:0] b,
                                           input logic [4:0] c, input logic [4:0] d);
    return {d, c, b, a};
  endfunction

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, return at the next falling edge.
  task automatic applyStimulus(input logic v, input logic [4:0] d, input logic f, input logic r);
    bus.valid_i = v;
    bus.data_i  = d;
    bus.flush_i = f;
    bus.ready_i = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hard stop in case the sequence ever runs away.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.flush_i = 1'b0;
    bus.ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_valid", bus.valid_o, 0);
    checkOutput("rst_pack",  bus.pack_o,  0);
    checkOutput("rst_cnt",   bus.cnt_o,   0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word 1,2,3,4: valid one edge after the 4th sample, for one cycle.
    $display("[TB] single word");
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 5'(i), 1'b0, 1'b1);
    checkOutput("t1_latency_low", bus.valid_o, 0);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
    checkOutput("t1_valid", bus.valid_o, 1);
    checkOutput("t1_pack",  bus.pack_o,  20'h20C41);
    checkOutput("t1_cnt",   bus.cnt_o,   4);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
    checkOutput("t1_valid_drop", bus.valid_o, 0);

    // Back-to-back samples 0..15 with ready high: four words, in order.
    $display("[TB] streaming");
    wordsSeen = 0;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) applyStimulus(1'b1, 5'(i), 1'b0, 1'b1);
      else        applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
      if (bus.valid_o) begin
        checkOutput("t2_word", bus.pack_o,
                    packWord(5'(4*wordsSeen), 5'(4*wordsSeen+1), 5'(4*wordsSeen+2), 5'(4*wordsSeen+3)));
        wordsSeen++;
      end
    end
    checkOutput("t2_words", wordsSeen, 4);
`ifdef TEST_PACKER_DROP_CNT_EN
    checkOutput("t2_drops", bus.drop_cnt_o, 0);
`endif

    // Stalled downstream: 10 samples, the last two are dropped.
    $display("[TB] stall");
    for (int i = 1; i <= 10; i++) applyStimulus(1'b1, 5'(i), 1'b0, 1'b0);
    checkOutput("t3_hold_valid", bus.valid_o, 1);
    checkOutput("t3_hold_pack",  bus.pack_o,  packWord(1, 2, 3, 4));
    checkOutput("t3_hold_cnt",   bus.cnt_o,   4);
`ifdef TEST_PACKER_DROP_CNT_EN
    checkOutput("t3_drops", bus.drop_cnt_o, 2);
`endif
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
    checkOutput("t3_second_valid", bus.valid_o, 1);
    checkOutput("t3_second_pack",  bus.pack_o,  packWord(5, 6, 7, 8));
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
    checkOutput("t3_empty_a", bus.valid_o, 0);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
    checkOutput("t3_empty_b", bus.valid_o, 0);

    // Flush of a 3-sample partial word, then a flush with nothing held.
    $display("[TB] flush");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 5'd7, 1'b0, 1'b1);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b1);
    checkOutput("t4_flush_edge", bus.valid_o, 0);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
    checkOutput("t4_valid", bus.valid_o, 1);
    checkOutput("t4_pack",  bus.pack_o,  20'h01CE7);
    checkOutput("t4_cnt",   bus.cnt_o,   3);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
    checkOutput("t4_after", bus.valid_o, 0);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b1);
    checkOutput("t4_empty_flush", bus.valid_o, 0);
    applyStimulus(1'b1, 5'd3, 1'b0, 1'b1);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
    checkOutput("t4_no_pending", bus.valid_o, 0);
    for (int i = 4; i <= 6; i++) applyStimulus(1'b1, 5'(i), 1'b0, 1'b1);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
    checkOutput("t4_full_pack", bus.pack_o, packWord(3, 4, 5, 6));
    checkOutput("t4_full_cnt",  bus.cnt_o,  4);

    // Reset mid-word: the partial word is discarded.
    $display("[TB] reset mid-word");
    applyStimulus(1'b1, 5'd9,  1'b0, 1'b1);
    applyStimulus(1'b1, 5'd10, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5a_valid", bus.valid_o, 0);
    checkOutput("t5a_pack",  bus.pack_o,  0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 11; i <= 14; i++) applyStimulus(1'b1, 5'(i), 1'b0, 1'b1);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
    checkOutput("t5a_fresh_pack", bus.pack_o, packWord(11, 12, 13, 14));
    checkOutput("t5a_fresh_cnt",  bus.cnt_o,  4);

    // Reset while a word is held against a stalled downstream.
    $display("[TB] reset during stall");
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 5'(i), 1'b0, 1'b0);
    checkOutput("t5b_stalled", bus.valid_o, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5b_valid", bus.valid_o, 0);
    checkOutput("t5b_pack",  bus.pack_o,  0);
    checkOutput("t5b_cnt",   bus.cnt_o,   0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 21; i <= 24; i++) applyStimulus(1'b1, 5'(i), 1'b0, 1'b1);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
    checkOutput("t5b_fresh_valid", bus.valid_o, 1);
    checkOutput("t5b_fresh_pack",  bus.pack_o,  packWord(21, 22, 23, 24));

`ifdef TEST_PACKER_DROP_CNT_EN
    // 308 samples into a stalled block: 8 stored, 300 dropped, count sticks at 255.
    $display("[TB] drop saturation");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 108; i++) applyStimulus(1'b1, 5'(i), 1'b0, 1'b0);
    checkOutput("t6_drops_100", bus.drop_cnt_o, 100);
    for (int i = 0; i < 200; i++) applyStimulus(1'b1, 5'(i), 1'b0, 1'b0);
    checkOutput("t6_drops_sat", bus.drop_cnt_o, 255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
